// File: rtl/instr_pkg.sv
// Shared encoding constants and FSM state type for the instruction encoder.
package instr_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Operation select codes on the op input
    localparam logic [1:0] OP_LH   = 2'd0;
    localparam logic [1:0] OP_SH   = 2'd1;
    localparam logic [1:0] OP_ANDI = 2'd2;
    localparam logic [1:0] OP_BNE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: builds an I/S/B-format word from decoded fields and
// reports whether the immediate fits its field without truncation.
module imm_pack
    import instr_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        range_ok
);

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] BOFF_MIN  = -32'sd4096;
    localparam logic signed [31:0] BOFF_MAX  = 32'sd4094;

    logic signed [31:0] simm;
    logic               fits_12;
    logic               fits_b;

    assign simm    = imm;
    assign fits_12 = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
    // Branch offsets are halfword-granular, so bit 0 must be clear.
    assign fits_b  = (simm >= BOFF_MIN) && (simm <= BOFF_MAX) && !imm[0];

    // Field packing per operation; unused register ports pass through unmasked.
    always_comb begin
        instr    = 32'h0;
        range_ok = 1'b1;
        unique case (op)
            OP_LH: begin
                instr    = {imm[11:0], rs1, F3_H, rd, OPC_LOAD};
                range_ok = fits_12;
            end
            OP_SH: begin
                instr    = {imm[11:5], rs2, rs1, F3_H, imm[4:0], OPC_STORE};
                range_ok = fits_12;
            end
            OP_ANDI: begin
                instr    = {imm[11:0], rs1, F3_AND, rd, OPC_OPIMM};
                range_ok = fits_12;
            end
            OP_BNE: begin
                instr    = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
                range_ok = fits_b;
            end
            default: begin
                instr    = 32'h0;
                range_ok = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field bundles, packs them into RISC-V words and
// streams them to instruction memory at incrementing byte addresses.
// Optional macro IMM_RANGE_CHECK_EN: reject bundles whose immediate does not
// fit its field and count them in err_count; otherwise immediates truncate.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_ptr_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              done_q, done_d;

    logic [31:0]       packed_instr;
    logic              range_ok;
    logic              accept;
    logic              out_fire;
    logic              emit;
    logic              start_run;

    imm_pack u_imm_pack (
        .op       (op),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .instr    (packed_instr),
        .range_ok (range_ok)
    );

    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign start_run = (state_q == StIdle) && start;

`ifdef IMM_RANGE_CHECK_EN
    logic [CNT_W-1:0] err_count_q;

    // A rejected bundle still consumes a slot in the run but emits nothing.
    assign emit = accept && range_ok;

    // Per-run saturating count of rejected bundles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= '0;
        end else if (start_run) begin
            err_count_q <= '0;
        end else if (accept && !range_ok && (err_count_q != '1)) begin
            err_count_q <= err_count_q + CNT_W'(1);
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_range_ok;

    assign unused_range_ok = range_ok;
    assign emit            = accept;
    assign err_count       = '0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_instr == '0) ? StDrain : StRun;
                end
            end
            StRun: begin
                if (accept && (remaining_q == CNT_W'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!out_valid_q || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; done is registered so it pulses the cycle after the run empties
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StRun: begin
                busy     = 1'b1;
                in_ready = (remaining_q != '0) && (!out_valid_q || out_ready);
            end
            StDrain: begin
                busy   = 1'b1;
                done_d = !out_valid_q || out_ready;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
                done_d   = 1'b0;
            end
        endcase
    end

    // Run address pointer and remaining-word counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_ptr_q  <= '0;
            remaining_q <= '0;
        end else if (start_run) begin
            addr_ptr_q  <= base_addr;
            remaining_q <= num_instr;
        end else begin
            if (emit) begin
                addr_ptr_q <= addr_ptr_q + ADDR_W'(4);
            end
            if (accept) begin
                remaining_q <= remaining_q - CNT_W'(1);
            end
        end
    end

    // Output stage: load on emit (even while handshaking), clear valid on drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_instr_q <= packed_instr;
            out_addr_q  <= addr_ptr_q;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    // Done pulse register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign done      = done_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Assembles RISC-V instruction words from decoded fields. It is the inverse of the datapath's immediate generator: it packs sign-extended immediates back into the I/S/B field layouts for lh, sh, andi and bne. It streams the encoded words, with incrementing byte addresses, into instruction memory for bench/program loading. A run is started with a base address and a word count. Fields are accepted via valid/ready, and one registered output stage supports back-pressure.

Parameters:
ADDR_W, 32, width of instruction-memory byte address
CNT_W, 8, width of run length / emitted-word counter

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begins run (ignored unless IDLE)
base_addr  in  ADDR_W  address of first word, must be 4-byte aligned
num_instr  in  CNT_W  words in run; 0 = run finishes immediately
in_valid  in  1  field bundle valid
in_ready  out  1  bundle accepted when in_valid && in_ready
op  in  2  0=lh, 1=sh, 2=andi, 3=bne
rd, rs1, rs2  in  5 each  register indices (rd unused for sh/bne, rs2 unused for lh/andi)
imm  in  32  signed byte immediate/offset
out_valid  out  1  instruction word valid
out_ready  in  1  memory accepts word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_instr
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when run completes
err_count  out  CNT_W  rejected bundles in current run (see Optional Feature)

Behaviour:
- Reset (async, immediate): state=IDLE; out_valid=0, out_instr=0, out_addr=0, in_ready=0, busy=0, done=0, err_count=0, counters 0.
- FSM:
  - IDLE: start latches base_addr into addr_ptr, num_instr into remaining, and clears err_count. Goes to RUN, or to DRAIN if num_instr==0.
  - RUN: in_ready = (remaining!=0) && (!out_valid || out_ready).
  - On accept: out_instr/out_addr load next cycle; out_valid=1; addr_ptr+=4; remaining-=1. When remaining reaches 0, go to DRAIN.
  - DRAIN: in_ready=0; wait until out_valid==0 or the current word is handshaked. Then pulse done for 1 cycle, go to IDLE.
- Latency: 1 cycle from accept to out_valid. Full throughput (1 word/cycle) while out_ready=1.
- Output is held stable (instr, addr, valid) while out_valid && !out_ready.
- A simultaneous accept and output handshake in the same cycle replaces the register with no bubble.
- Encodings (funct3: lh=001, sh=001, andi=111, bne=001):
  - lh: imm[11:0]|rs1|funct3|rd|0000011
  - andi: imm[11:0]|rs1|funct3|rd|0010011
  - sh: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011
  - bne: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011
- Unused register fields are encoded from the corresponding port unchanged (no masking), except rd is absent in S/B formats.
- start during RUN/DRAIN is ignored.
- addr_ptr wraps modulo 2^ADDR_W.
- Reset mid-run aborts immediately: no done pulse, pending word discarded.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined:
  - I/S ops require -2048 <= imm <= 2047.
  - bne requires -4096 <= imm <= 4094 and imm[0]==0.
  - A violating bundle is consumed (in_ready handshake occurs) but produces no word. addr_ptr is not advanced, remaining is decremented, and err_count increments (saturating).
- Undefined: imm is silently truncated to the field bits; err_count is tied to 0.

Decomposition:
- Shared package instr_pkg holds:
  - opcode constants OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, OPC_OPIMM=7'b0010011, OPC_BRANCH=7'b1100011;
  - funct3 constants F3_H=3'b001, F3_AND=3'b111, F3_BNE=3'b001;
  - op-select codes OP_LH..OP_BNE.
- One combinational sub-module, imm_pack, takes (op, rd, rs1, rs2, imm) and produces (instr, range_ok). The top holds the FSM, counters and output register.

Test Plan:
- andi x5,x6,0xFF, base 0x100, num=1 -> out_instr=0x0FF37293, out_addr=0x100, done pulses 1 cycle after handshake.
- lh x1,-4(x2) then sh x3,8(x4), base 0x0, num=2, out_ready=1 -> words 0xFFC11083@0x0, 0x00321423@0x4 on consecutive cycles.
- bne x1,x2,-8 with out_ready held 0 for 3 cycles -> out_instr=0xFE209CE3 stable, in_ready=0, released on out_ready=1.
- num=0 start -> no out_valid, done pulse, busy low.
- With IMM_RANGE_CHECK_EN: andi imm=4096 then andi x5,x6,0xFF, num=2 -> err_count=1, single word 0x0FF37293 at base. Without the macro: two words, first with imm field 0x000.
- Reset asserted while out_valid=1 mid-run -> all outputs 0 immediately, no done pulse.
